// File: rtl/mag_framer.sv
// mag_framer
//   Converts a stream of unsigned magnitudes into framed bytes for a UART
//   transmitter.
//   Frame layout: sync0_p, sync1_p, frame_w_p*frame_h_p pixel bytes, then an
//   8-bit checksum. The checksum is the modulo-256 sum of the pixel bytes.
//   Each pixel byte is an 8-bit window data_i[shift_p+7:shift_p]. The byte
//   saturates to 8'hFF when any magnitude bit above the window is set.
//
// Parameters
//   width_in_p  magnitude input width
//   shift_p     LSB index of the 8-bit output window
//   frame_w_p   pixels per line
//   frame_h_p   lines per frame
//   sync0_p     first header byte
//   sync1_p     second header byte
//
// Ports
//   clk_i         single rising-edge clock
//   reset_i       synchronous active-high reset
//   valid_i       upstream magnitude valid
//   data_i        unsigned magnitude
//   ready_o       block accepts data_i this cycle (pixel phase only)
//   valid_o       byte on data_o valid
//   data_o        framed byte stream
//   ready_i       downstream accepts byte
//   frame_done_o  one-cycle pulse when the checksum byte handshakes
module mag_framer #(
  parameter int unsigned width_in_p = 15,
  parameter int unsigned shift_p    = 3,
  parameter int unsigned frame_w_p  = 161,
  parameter int unsigned frame_h_p  = 120,
  parameter logic [7:0]  sync0_p    = 8'hA5,
  parameter logic [7:0]  sync1_p    = 8'h5A
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  valid_i,
  input  logic [width_in_p-1:0] data_i,
  output logic                  ready_o,
  output logic                  valid_o,
  output logic [7:0]            data_o,
  input  logic                  ready_i,
  output logic                  frame_done_o
);

  localparam int unsigned ColW = (frame_w_p > 1) ? $clog2(frame_w_p) : 1;
  localparam int unsigned RowW = (frame_h_p > 1) ? $clog2(frame_h_p) : 1;
  localparam logic [ColW-1:0] ColLast = ColW'(frame_w_p - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(frame_h_p - 1);

  typedef enum logic [1:0] {
    HDR0,
    HDR1,
    PIX,
    CSUM
  } state_e;

  state_e          state_q, state_d;
  logic            valid_q, valid_d;
  logic [7:0]      data_q, data_d;
  logic            csum_out_q, csum_out_d;  // output register holds checksum
  logic [7:0]      csum_q, csum_d;
  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;

  logic            out_free;
  logic            accept;
  logic [width_in_p+7:0] pix_ext;
  logic [7:0]      pix_byte;

  // Extend the input by 8 zero bits before shifting it. The window is then
  // always pix_ext[7:0] and any bit above it lands in pix_ext[width+7:8].
  // This form also covers the narrow-input case: no bits exist above the
  // window there, so the result is only zero-extended.
  assign pix_ext  = {8'h00, data_i} >> shift_p;
  assign pix_byte = (|pix_ext[width_in_p+7:8]) ? 8'hFF : pix_ext[7:0];

  // The output register may be (re)loaded when it is empty or draining.
  assign out_free = ~valid_q | ready_i;
  assign ready_o  = (state_q == PIX) & out_free & ~reset_i;
  assign accept   = valid_i & ready_o;

  assign valid_o      = valid_q;
  assign data_o       = data_q;
  assign frame_done_o = valid_q & ready_i & csum_out_q & ~reset_i;

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    data_d     = data_q;
    csum_out_d = csum_out_q;
    csum_d     = csum_q;
    col_d      = col_q;
    row_d      = row_q;

    // A drained or empty register becomes empty unless a state below reloads it.
    if (out_free) begin
      valid_d    = 1'b0;
      csum_out_d = 1'b0;
    end

    case (state_q)
      HDR0: begin
        if (out_free) begin
          valid_d = 1'b1;
          data_d  = sync0_p;
          state_d = HDR1;
        end
      end
      HDR1: begin
        if (out_free) begin
          valid_d = 1'b1;
          data_d  = sync1_p;
          csum_d  = '0;
          state_d = PIX;
        end
      end
      PIX: begin
        if (accept) begin
          valid_d = 1'b1;
          data_d  = pix_byte;
          csum_d  = csum_q + pix_byte;
          if (col_q == ColLast) begin
            col_d = '0;
            if (row_q == RowLast) begin
              row_d   = '0;
              state_d = CSUM;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      CSUM: begin
        if (out_free) begin
          valid_d    = 1'b1;
          data_d     = csum_q;
          csum_out_d = 1'b1;
          state_d    = HDR0;
        end
      end
      default: state_d = HDR0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= HDR0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      csum_out_q <= 1'b0;
      csum_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      csum_out_q <= csum_out_d;
      csum_q     <= csum_d;
      col_q      <= col_d;
      row_q      <= row_d;
    end
  end

endmodule

// File: tb/tb_mag_framer.sv
module tb_mag_framer;

  localparam int W    = 15;
  localparam int SH   = 3;
  localparam int FW   = 2;
  localparam int FH   = 2;
  localparam int NPIX = FW * FH;
  localparam logic [7:0] REF37 [7] = '{8'hA5, 8'h5A, 8'h01, 8'hFF, 8'hFF, 8'h00, 8'hFF};

  logic         clk = 1'b0;
  logic         reset_i = 1'b1;
  logic         valid_i = 1'b0;
  logic [W-1:0] data_i = '0;
  logic         ready_o;
  logic         valid_o;
  logic [7:0]   data_o;
  logic         ready_i = 1'b0;
  logic         frame_done_o;

  always #5 clk = ~clk;

  mag_framer #(
    .width_in_p(W),
    .shift_p   (SH),
    .frame_w_p (FW),
    .frame_h_p (FH),
    .sync0_p   (8'hA5),
    .sync1_p   (8'h5A)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .valid_i     (valid_i),
    .data_i      (data_i),
    .ready_o     (ready_o),
    .valid_o     (valid_o),
    .data_o      (data_o),
    .ready_i     (ready_i),
    .frame_done_o(frame_done_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: position within the byte stream of a frame,
  // running sum, pixels already accepted but not yet seen at the output.
  logic [W-1:0] src_q[$];
  logic [7:0]   acc_q[$];
  logic [7:0]   log_q[$];
  int           hs_cyc_q[$];
  int           pos = 0;
  logic [7:0]   sum = '0;
  int           frames = 0;
  int           hs_count = 0;
  int           acc_total = 0;
  int           cyc = 0;
  logic         prev_stall = 1'b0;
  logic [7:0]   prev_data = '0;
  logic         lat_pend = 1'b0;
  logic [7:0]   lat_byte = '0;
  logic         post_rst = 1'b0;

  function automatic logic [7:0] pix_model(input logic [W-1:0] v);
    int unsigned x;
    x = v;
    if ((x >> (SH + 8)) != 0) return 8'hFF;
    return 8'((x >> SH) % 256);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pos = 0;
    sum = '0;
    acc_q.delete();
    log_q.delete();
    hs_cyc_q.delete();
    hs_count = 0;
    prev_stall = 1'b0;
    lat_pend = 1'b0;
  endtask

  // One clock cycle: drive inputs, sample at the falling edge, update model.
  task automatic cycle(input logic rst, input logic vin_en, input logic rdy);
    logic [7:0] e;
    logic [7:0] b;
    logic       exp_fd;
    reset_i = rst;
    ready_i = rdy;
    if (!rst && vin_en && src_q.size() > 0) begin
      valid_i = 1'b1;
      data_i  = src_q[0];
    end else begin
      valid_i = 1'b0;
      data_i  = W'($urandom);
    end
    @(negedge clk);
    if (rst) begin
      chk("rst_ready", ready_o, 0);
      chk("rst_fdone", frame_done_o, 0);
    end else begin
      if (post_rst) begin
        chk("post_rst_valid", valid_o, 0);
        chk("post_rst_data", data_o, 0);
      end
      if (prev_stall) begin
        chk("stall_valid", valid_o, 1);
        chk("stall_data", data_o, prev_data);
      end
      if (lat_pend) begin
        chk("lat1_valid", valid_o, 1);
        chk("lat1_data", data_o, lat_byte);
      end
      if (ready_o) chk("ready_free", (!valid_o) | ready_i, 1);
      exp_fd = 1'b0;
      if (valid_o && ready_i) begin
        hs_count++;
        hs_cyc_q.push_back(cyc);
        log_q.push_back(data_o);
        if (pos == 0) e = 8'hA5;
        else if (pos == 1) e = 8'h5A;
        else if (pos < NPIX + 2) begin
          chk("pix_avail", acc_q.size() != 0, 1);
          e = (acc_q.size() != 0) ? acc_q.pop_front() : 8'h00;
        end else begin
          e = sum;
          exp_fd = 1'b1;
        end
        chk("byte", data_o, e);
        if (exp_fd) begin
          pos = 0;
          sum = '0;
          frames++;
        end else begin
          pos++;
        end
      end
      chk("fdone", frame_done_o, exp_fd);
      if (valid_i && ready_o) begin
        b = pix_model(src_q.pop_front());
        acc_q.push_back(b);
        sum = sum + b;
        acc_total++;
        lat_pend = 1'b1;
        lat_byte = b;
      end else begin
        lat_pend = 1'b0;
      end
      prev_stall = valid_o & ~ready_i;
      prev_data  = data_o;
    end
    post_rst = rst;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) model_reset();
  endtask

  task automatic run_frames(input int target, input int vprob, input int rprob, input int bound);
    int n;
    n = 0;
    while (frames < target && n < bound) begin
      cycle(1'b0, $urandom_range(99) < vprob, $urandom_range(99) < rprob);
      n++;
    end
    chk("frame_timeout", frames >= target, 1);
  endtask

  task automatic check_ref37(input string tag);
    chk({tag, "_len"}, log_q.size(), 7);
    for (int i = 0; i < 7; i++)
      if (i < log_q.size()) chk(tag, log_q[i], REF37[i]);
  endtask

  initial begin
    int n;
    int tgt;
    // Reset
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);

    // Idle with ready_i=1: headers only, then waiting in pixel phase
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1);
    chk("idle_valid", valid_o, 0);
    chk("idle_ready", ready_o, 1);
    chk("idle_bytes", hs_count, 2);

    // Directed 2x2 frame, continuous flow
    src_q = '{15'h0008, 15'h07F8, 15'h0800, 15'h0000};
    tgt = frames + 1;
    run_frames(tgt, 100, 100, 50);
    check_ref37("frame37");

    // Same frame with random stalls on both sides
    cycle(1'b1, 1'b0, 1'b0);
    src_q = '{15'h0008, 15'h07F8, 15'h0800, 15'h0000};
    tgt = frames + 1;
    run_frames(tgt, 50, 50, 400);
    check_ref37("frame38");

    // Two back-to-back frames at full rate: 14 bytes in 14 consecutive cycles
    cycle(1'b1, 1'b0, 1'b1);
    src_q.delete();
    for (int i = 0; i < 2 * NPIX; i++) src_q.push_back(W'($urandom));
    tgt = frames + 2;
    run_frames(tgt, 100, 100, 60);
    chk("b2b_count", hs_count, 14);
    if (hs_cyc_q.size() == 14) chk("b2b_span", hs_cyc_q[13] - hs_cyc_q[0], 13);

    // Reset after two pixels of a frame
    cycle(1'b1, 1'b0, 1'b1);
    src_q = '{15'h1234, 15'h0FFF, 15'h0100, 15'h7FFF};
    tgt = acc_total + 2;
    n = 0;
    while (acc_total < tgt && n < 20) begin
      cycle(1'b0, 1'b1, 1'b1);
      n++;
    end
    chk("midrst_timeout", acc_total >= tgt, 1);
    cycle(1'b1, 1'b0, 1'b1);
    src_q = '{15'h0008, 15'h07F8, 15'h0800, 15'h0000};
    tgt = frames + 1;
    run_frames(tgt, 100, 100, 50);
    check_ref37("midrst");

    // Random pixel values across the full input range with random stalls
    for (int i = 0; i < 3 * NPIX; i++) begin
      if (i % 3 == 0) src_q.push_back(W'($urandom_range(2047)));
      else src_q.push_back(W'($urandom));
    end
    tgt = frames + 3;
    run_frames(tgt, 60, 60, 1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mag_framer.md
MAG_FRAMER -- requirements
Module: mag_framer

Interface
REQ-001 SHALL have parameter width_in_p, default 15, magnitude input width in bits.
REQ-002 SHALL have parameter shift_p, default 3, LSB index of the 8-bit output window.
REQ-003 SHALL have parameter frame_w_p, default 161, pixels per line.
REQ-004 SHALL have parameter frame_h_p, default 120, lines per frame.
REQ-005 SHALL have parameter sync0_p, default 8'hA5, first header byte.
REQ-006 SHALL have parameter sync1_p, default 8'h5A, second header byte.
REQ-007 SHALL have port clk_i, input, 1, single clock; all logic rising-edge.
REQ-008 SHALL have port reset_i, input, 1, synchronous active-high reset.
REQ-009 SHALL have port valid_i, input, 1, upstream magnitude valid.
REQ-010 SHALL have port data_i, input, width_in_p, unsigned magnitude.
REQ-011 SHALL have port ready_o, output, 1, block accepts data_i this cycle.
REQ-012 SHALL have port valid_o, output, 1, byte on data_o valid (feeds UART tx).
REQ-013 SHALL have port data_o, output, 8, framed byte stream.
REQ-014 SHALL have port ready_i, input, 1, downstream UART accepts byte.
REQ-015 SHALL have port frame_done_o, output, 1, one-cycle pulse at end of frame.

Function
REQ-016 SHALL hold valid_o/data_o in an output register, changed only when the register is empty (valid_o=0) or drained (valid_o & ready_i).
REQ-017 SHALL, while valid_o=1 and ready_i=0, hold data_o stable.
REQ-018 SHALL use FSM states HDR0, HDR1, PIX, CSUM, entered HDR0 out of reset.
REQ-019 SHALL in HDR0 load sync0_p into the output register when free, then go to HDR1.
REQ-020 SHALL in HDR1 load sync1_p when free, clear checksum, then go to PIX.
REQ-021 SHALL assert ready_o = (state==PIX) & (~valid_o | ready_i), combinationally; ready_o=0 in all other states.
REQ-022 SHALL on valid_i & ready_o load the pixel byte into the output register the next cycle (latency 1 cycle, input handshake to valid_o).
REQ-023 SHALL form pixel byte = 8'hFF if any bit of data_i above bit shift_p+7 is set, else data_i[shift_p+7:shift_p].
REQ-024 SHALL, if shift_p+7 >= width_in_p-1, use only existing bits, zero-extended, no saturation.
REQ-025 SHALL add each accepted pixel byte into an 8-bit checksum, modulo 256.
REQ-026 SHALL keep column counter 0..frame_w_p-1 and row counter 0..frame_h_p-1, advanced per accepted pixel; column wraps to 0 and row increments at column frame_w_p-1.
REQ-027 SHALL on the accept with column=frame_w_p-1 and row=frame_h_p-1 clear both counters and go to CSUM.
REQ-028 SHALL in CSUM load the final checksum (including last pixel) when free, then go to HDR0.
REQ-029 SHALL pulse frame_done_o for exactly one cycle when the checksum byte handshakes (valid_o & ready_i while holding checksum).
REQ-030 SHALL sustain one byte per cycle when ready_i is held 1, with no bubbles between header, pixel and checksum bytes.
REQ-031 SHALL not drop or duplicate any accepted pixel under arbitrary valid_i/ready_i stalls.
REQ-032 SHALL ignore valid_i in HDR0, HDR1, CSUM (data held upstream via ready_o=0).

Reset
REQ-033 SHALL on reset_i=1 set valid_o=0, data_o=8'h00, frame_done_o=0, state=HDR0, counters=0, checksum=0.
REQ-034 SHALL, on reset mid-frame, discard partial frame and checksum; first byte after reset is sync0_p.
REQ-035 SHALL hold ready_o=0 during reset.

Verification
REQ-036 Reset then ready_i=1, no valid_i -> bytes A5, 5A, then valid_o=0, ready_o=1 indefinitely.
REQ-037 frame 2x2, shift_p=3, inputs 0x0008,0x07F8,0x0800,0x0000, ready_i=1 -> A5,5A,01,FF,FF,00,FF(checksum); frame_done_o one pulse on FF checksum handshake.
REQ-038 Same as REQ-037 with ready_i toggling random 50% and valid_i random gaps -> identical byte sequence, data_o stable while stalled.
REQ-039 Two back-to-back 2x2 frames, ready_i=1 -> 14 bytes, second frame starts A5 immediately after first checksum, checksum restarts from 0.
REQ-040 Assert reset_i after 2 pixels of a 2x2 frame -> valid_o=0 next cycle; following output begins A5,5A and full correct frame.
